// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
// Package : mips_defs
// Purpose : Shared definitions for the MIPS multiply/divide unit: operation
//           encodings, controller state encodings and the default width.
// Revision: 1.0 - initial release
// ============================================================================
package mips_defs;

  localparam int DEFAULT_WIDTH = 32;

  // op[1] selects divide, op[0] selects the signed variant.
  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_negate.sv
`default_nettype none
// ============================================================================
// Module  : mdu_negate
// Purpose : Combinational conditional two's-complement negation.
// Ports   : in  [WIDTH-1:0] - value
//           neg             - 1: out = -in, 0: out = in
//           out [WIDTH-1:0] - result
// Revision: 1.0 - initial release
// ============================================================================
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  assign out = neg ? (~in + WIDTH'(1)) : in;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : mult_div_unit
// Purpose : Iterative MULT/MULTU/DIV/DIVU unit producing the HI/LO pair.
//           Shift-add multiply and restoring divide, one bit per cycle;
//           WIDTH cycles from the accepting edge to the done pulse.
// Ports   : clock, reset (async, active-high)
//           start, op[1:0], a, b  - request, sampled when not busy
//           busy                  - high while iterating
//           done                  - one-cycle pulse, hi/lo valid from here
//           hi, lo                - product halves / remainder, quotient
// Config  : MULTDIV_SIGNED_EN - when defined, op[0]=1 selects the signed
//           operation (magnitude/negation logic built); otherwise op[0] is
//           ignored and all operations are unsigned.
// Revision: 1.0 - initial release
// ============================================================================
module mult_div_unit
  import mips_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_t           state;
  logic [CNT_W-1:0]     count;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     a_raw;   // original dividend, for divide-by-zero
  logic                 is_div;
  logic                 b_zero;
  logic                 neg_q;   // product / quotient needs negation
  logic                 neg_rem; // remainder needs negation

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 a_neg_in;
  logic                 b_neg_in;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   acc_next;

  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

`ifdef MULTDIV_SIGNED_EN
  assign a_neg_in = op[0] & a[WIDTH-1];
  assign b_neg_in = op[0] & b[WIDTH-1];

  mdu_negate #(.WIDTH(WIDTH)) u_neg_a (
    .in (a),
    .neg(a_neg_in),
    .out(a_mag)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_neg_b (
    .in (b),
    .neg(b_neg_in),
    .out(b_mag)
  );

  mdu_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
    .in (acc_next),
    .neg(neg_q),
    .out(prod_fix)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_neg_quot (
    .in (acc_next[WIDTH-1:0]),
    .neg(neg_q),
    .out(quot_fix)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .in (acc_next[2*WIDTH-1:WIDTH]),
    .neg(neg_rem),
    .out(rem_fix)
  );
`else
  assign a_neg_in = 1'b0;
  assign b_neg_in = 1'b0;
  assign a_mag    = a;
  assign b_mag    = b;
  assign prod_fix = acc_next;
  assign quot_fix = acc_next[WIDTH-1:0];
  assign rem_fix  = acc_next[2*WIDTH-1:WIDTH];

  logic unused_sign;
  assign unused_sign = ^{op[0], neg_q, neg_rem};
`endif

  // One iteration of either algorithm.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_next = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Shift the next dividend bit into the remainder and try subtracting.
    // The restoring invariant (remainder < divisor) keeps the borrow in
    // trial[WIDTH]; a zero divisor breaks it, but that case is overridden.
    trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    acc_next = is_div ? div_next : mul_next;
  end

  // Final result as written on the last iteration edge.
  always_comb begin
    res_hi = is_div ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
    res_lo = is_div ? quot_fix : prod_fix[WIDTH-1:0];
    if (is_div && b_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      opnd    <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      b_zero  <= 1'b0;
      neg_q   <= 1'b0;
      neg_rem <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            is_div  <= op[1];
            // Multiply keeps the multiplier in the low half; divide keeps
            // the dividend there.
            acc     <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            opnd    <= op[1] ? b_mag : a_mag;
            a_raw   <= a;
            b_zero  <= (b == '0);
            neg_q   <= a_neg_in ^ b_neg_in;
            neg_rem <= a_neg_in;
            count   <= CNT_W'(WIDTH);
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            hi    <= res_hi;
            lo    <= res_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_div_unit
// Purpose : Self-checking bench for mult_div_unit. Expected HI/LO pairs are
//           queued as operations are issued and compared on each done pulse.
//           Honors MULTDIV_SIGNED_EN the same way the design does.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Architectural reference: {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic   sgn;
    longint sx, sy;
`ifdef MULTDIV_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o[1]) begin
      if (sgn) return 64'(sx * sy);
      return {32'd0, x} * {32'd0, y};
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (sgn) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      return {32'(sx % sy), 32'(sx / sy)};
    end
    return {x % y, x / y};
  endfunction

  // Scoreboard side: every done pulse pops one expectation.
  int busy_run = 0;
  always @(negedge clock) begin
    logic [63:0] e;
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'(done), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("hi", 64'(hi), 64'(e[63:32]));
          check("lo", 64'(lo), 64'(e[31:0]));
          check("busy_cycles", 64'(busy_run), 64'(32));
        end
        busy_run = 0;
      end
    end
  end

  // Called at a negedge with the unit idle or in its done cycle.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clock);
    start = 1'b0;
    // Operands are latched; changing them now must not matter.
    op    = ~o;
    a     = $urandom;
    b     = $urandom;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ehi, input logic [31:0] elo);
    exp_q.push_back({ehi, elo});
    start_op(o, x, y);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) return;
    end
    check("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] m;

    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Directed cases.
    issue(OP_MULTU, 32'hDEAD_BEEF, 32'd2, 32'h0000_0001, 32'hBD5B_7DDE);
    wait_done();
    issue(OP_DIVU, 32'h0000_BABE, 32'h10, 32'h0000_000E, 32'h0000_0BAB);
    wait_done();
`ifdef MULTDIV_SIGNED_EN
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    wait_done();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    wait_done();
    issue(OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    wait_done();
`else
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    wait_done();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
    wait_done();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
    wait_done();
`endif
    issue(OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
    wait_done();

    // Back-to-back: next start issued in the done cycle.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done();
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd7, 32'h0000_0003, 32'h2492_4924);
    wait_done();

    // Random operations against the reference model.
    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i % 4 == 1) ra = -ra;
      m = model(ro, ra, rb);
      issue(ro, ra, rb, m[63:32], m[31:0]);
      wait_done();
    end

    // Start while busy is dropped: the original operation completes.
    issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080);
    repeat (4) @(negedge clock);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    wait_done();
    @(negedge clock);
    check("no_queued_start", 64'(busy), 64'(0));

    // Reset in the middle of an operation.
    start_op(OP_MULTU, 32'hDEAD_BEEF, 32'd7);
    repeat (3) @(negedge clock);
    start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);   // any stray done is flagged by the scoreboard
    check("abort_idle", 64'(busy), 64'(0));
    issue(OP_MULTU, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
    wait_done();
    repeat (3) @(negedge clock);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
